// File: rtl/task_1_pkg.sv
// Shared constants and state encoding for the task 1 ingress/egress stages.
package task_1_pkg;

  localparam int unsigned T1_DATA_WIDTH = 8;
  localparam int unsigned T1_NUM_WORDS  = 81;
  localparam int unsigned T1_MAX_VALUE  = 9;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned T1_PTR_W = ptr_width(T1_NUM_WORDS);

  typedef enum logic [1:0] {
    S_RECV   = 2'd0,
    S_DROP   = 2'd1,
    S_STREAM = 2'd2
  } t1_in_state_e;

endpackage

// File: rtl/task_1_in_buf.sv
// Packet buffer for task_1_in: NUM_WORDS x DATA_WIDTH registers, one write port,
// combinational read port.
module task_1_in_buf
  import task_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = T1_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = T1_NUM_WORDS,
  parameter int unsigned ADDR_W     = ptr_width(T1_NUM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/task_1_in.sv
// Task 1 ingress: buffers one NUM_WORDS request packet, checks its length and replays it
// to the core. Optional value-range check enabled by TASK_1_IN_RANGE_CHECK_EN.
module task_1_in
  import task_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = T1_DATA_WIDTH,
  parameter int unsigned NUM_WORDS  = T1_NUM_WORDS,
  parameter int unsigned MAX_VALUE  = T1_MAX_VALUE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tmanager_data,
  input  logic                  i_tmanager_valid,
  input  logic                  i_tmanager_last,
  output logic                  o_tmanager_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  input  logic                  i_core_ready,
  output logic                  o_input_last,
  output logic                  o_busy,
  output logic                  o_len_error,
  output logic                  o_value_error,
  output logic [15:0]           o_packet_count
);

  localparam int unsigned      PTR_W    = ptr_width(NUM_WORDS);
  localparam logic [PTR_W:0]   N_FULL   = (PTR_W+1)'(NUM_WORDS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_WORDS - 1);

  t1_in_state_e     state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             len_err_q, len_err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [PTR_W:0]   n_words;
  logic             rx_fire;
  logic             rx_end_full;
  logic             bad_now;

  assign o_tmanager_ready = (state_q == S_RECV) || (state_q == S_DROP);
  assign o_data_valid     = (state_q == S_STREAM);
  assign o_busy           = (state_q == S_STREAM);
  assign o_input_last     = o_data_valid && (rd_ptr_q == LAST_IDX);
  assign o_len_error      = len_err_q;
  assign o_packet_count   = cnt_q;

  assign rx_fire     = i_tmanager_valid && o_tmanager_ready;
  assign n_words     = {1'b0, wr_ptr_q} + (PTR_W+1)'(1);
  assign rx_end_full = (state_q == S_RECV) && i_tmanager_valid && i_tmanager_last
                       && (n_words == N_FULL);

  task_1_in_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_W     (PTR_W)
  ) u_buf (
    .i_clk (i_clk),
    .we    ((state_q == S_RECV) && i_tmanager_valid),
    .waddr (wr_ptr_q),
    .wdata (i_tmanager_data),
    .raddr (rd_ptr_q),
    .rdata (o_data)
  );

`ifdef TASK_1_IN_RANGE_CHECK_EN
  // Sticky flag covers every word of the current packet; the current beat is folded
  // in combinationally so a bad final word is still caught.
  logic bad_q, bad_d, val_err_q;

  assign bad_now = bad_q || (rx_fire && (i_tmanager_data > DATA_WIDTH'(MAX_VALUE)));

  always_comb begin
    bad_d = bad_now;
    if (rx_fire && i_tmanager_last) bad_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bad_q     <= 1'b0;
      val_err_q <= 1'b0;
    end else begin
      bad_q     <= bad_d;
      val_err_q <= rx_end_full && bad_now;
    end
  end

  assign o_value_error = val_err_q;
`else
  assign bad_now       = 1'b0;
  assign o_value_error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    len_err_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_RECV: begin
        if (i_tmanager_valid) begin
          if (i_tmanager_last) begin
            wr_ptr_d = '0;
            if (n_words == N_FULL) begin
              if (!bad_now) begin
                state_d  = S_STREAM;
                rd_ptr_d = '0;
              end
            end else begin
              len_err_d = 1'b1;
            end
          end else if (n_words == N_FULL) begin
            state_d  = S_DROP;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      S_DROP: begin
        if (i_tmanager_valid && i_tmanager_last) begin
          len_err_d = 1'b1;
          state_d   = S_RECV;
          wr_ptr_d  = '0;
        end
      end
      S_STREAM: begin
        if (i_core_ready) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d  = S_RECV;
            cnt_d    = cnt_q + 16'd1;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_RECV;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_RECV;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: doc/task_1_in.md
Name: task_1_in

Overview:
- Ingress stage for task 1. Accepts one request packet of NUM_WORDS bytes from the task manager over a valid/ready/last stream and buffers it in a register array.
- Checks packet length (and optionally value range). Replays the packet to the task 1 processing core, which finishes into task_1_out.
- The core-side stream uses the same data/valid/last semantics task_1_out consumes (i_data, i_data_valid, i_input_last).

Parameters:
- DATA_WIDTH, 8, width of every word on both sides.
- NUM_WORDS, 81, exact number of words in a legal packet (9x9 grid).
- MAX_VALUE, 9, largest legal word value; used only with the optional feature.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_tmanager_data  in  DATA_WIDTH  request word from task manager.
- i_tmanager_valid  in  1  request word valid.
- i_tmanager_last  in  1  final word of request packet.
- o_tmanager_ready  out  1  block can accept a request word.
- o_data  out  DATA_WIDTH  word to core.
- o_data_valid  out  1  o_data valid.
- i_core_ready  in  1  core accepts o_data this cycle.
- o_input_last  out  1  final word to core; qualifies with o_data_valid.
- o_busy  out  1  packet held or being streamed (S_STREAM).
- o_len_error  out  1  one-cycle pulse: packet discarded for wrong length.
- o_value_error  out  1  one-cycle pulse: packet discarded for out-of-range word (feature only).
- o_packet_count  out  16  number of good packets delivered to core; wraps at 2^16.

Behaviour:
- Reset (async assert, sync deassert release): state=S_RECV, wr_ptr=0, rd_ptr=0, all pulses 0, o_packet_count=0, o_data_valid=0, o_busy=0. o_tmanager_ready=1 from the first clock after reset release.
- Handshake: a beat transfers when valid&&ready on a rising edge, on both sides. Source may not drop valid or change data before acceptance.
- S_RECV: o_tmanager_ready=1. Each accepted beat writes mem[wr_ptr] and increments wr_ptr. On the accepted beat, with n = wr_ptr+1 (words including this one):
  - last && n==NUM_WORDS -> S_STREAM next cycle, rd_ptr=0.
  - last && n<NUM_WORDS -> o_len_error pulse next cycle, wr_ptr=0, stay S_RECV (short packet dropped).
  - !last && n==NUM_WORDS -> S_DROP.
- S_DROP: o_tmanager_ready=1. Discard beats until an accepted last, then o_len_error pulse, wr_ptr=0, go to S_RECV. Buffer contents are never streamed.
- S_STREAM:
  - o_tmanager_ready=0, o_busy=1, o_data_valid=1.
  - o_data=mem[rd_ptr] (rd_ptr registered, read is combinational from the array).
  - o_input_last=(rd_ptr==NUM_WORDS-1).
  - Each i_core_ready increments rd_ptr.
  - On the accepted last word: o_packet_count+1, wr_ptr=0, go to S_RECV. o_data_valid and o_busy are 0 the next cycle.
- Latency: first core word valid 1 cycle after the accepted request last. Stream throughput is 1 word/cycle when i_core_ready is held high.
- Request side is blocked while streaming; there is no overlap of receive and stream. Last word to core and the next request beat cannot occur in the same cycle.
- Pointers: width $clog2(NUM_WORDS). They never exceed NUM_WORDS-1; length checks use wr_ptr+1 computed one bit wider.
- Reset mid-packet: all progress lost, no error pulse, o_packet_count cleared.
- Illegal state encodings return to S_RECV.

Optional Feature:
- Macro: TASK_1_IN_RANGE_CHECK_EN.
- With macro: each accepted request word > MAX_VALUE sets a sticky bad flag. At the end of a packet of correct length with the flag set, the packet is not streamed; o_value_error pulses 1 cycle, return to S_RECV, flag cleared.
  - Length error takes priority: only o_len_error pulses.
  - The flag is cleared on every packet end and on reset.
- Without macro: no comparator logic; o_value_error tied 0.

Decomposition:
- Shared package task_1_pkg: task_1_in state enum (S_RECV, S_DROP, S_STREAM), localparam defaults for NUM_WORDS=81 and DATA_WIDTH=8, and a localparam for the pointer width function, so task_1_in and task_1_out use the same constants.
- One natural sub-module: task_1_in_buf, the NUM_WORDS x DATA_WIDTH register array with write port (we, waddr, wdata) and combinational read port (raddr, rdata). The FSM and counters stay in task_1_in.

Test Plan:
- 81 words 0..80 (mod 256), last on word 81, i_core_ready=1 -> o_data 0..80 on 81 consecutive cycles starting 1 cycle after the last beat, o_input_last only with 80, o_packet_count=1, o_tmanager_ready=0 throughout.
- 40-word packet with last on word 40 -> o_len_error single pulse, no o_data_valid. A following good 81-word packet streams correctly.
- 85-word packet -> o_tmanager_ready stays 1 for all 85 beats, one o_len_error pulse after beat 85, nothing streamed.
- Good packet with i_core_ready toggling 1/0 every cycle -> 81 words delivered in order over 161 cycles, o_data stable while not accepted.
- Assert i_rst asynchronously after 30 accepted request words -> outputs return to reset values immediately, then an 81-word packet streams correctly and o_packet_count=1.
- With TASK_1_IN_RANGE_CHECK_EN: 81 words with word 10 = 12 -> o_value_error pulse, no stream. Same packet without macro -> streamed, o_value_error stays 0.
